// File: rtl/ras_pkg.sv
// Shared decode constants, FSM state type and JAL/JALR classification helpers
// for the return-address-stack controller.
package ras_pkg;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [4:0] LNK_X1 = 5'd1;
  localparam logic [4:0] LNK_X5 = 5'd5;

  typedef enum logic {
    RUN,
    FLUSH
  } ras_state_e;

  function automatic logic is_link(input logic [4:0] rd);
    return (rd == LNK_X1) || (rd == LNK_X5);
  endfunction

  function automatic logic is_call(input logic [31:0] instr);
    logic [6:0] opc;
    opc = instr[6:0];
    return ((opc == OPC_JAL) || (opc == OPC_JALR)) && is_link(instr[11:7]);
  endfunction

  // JALR x1,x1 is a plain call; JALR x1,x5 (or x5,x1) is a coroutine swap.
  function automatic logic is_ret(input logic [31:0] instr);
    logic [4:0] rd;
    logic [4:0] rs1;
    rd  = instr[11:7];
    rs1 = instr[19:15];
    return (instr[6:0] == OPC_JALR) && is_link(rs1) &&
           ((rd == 5'd0) || (is_link(rd) && (rd != rs1)));
  endfunction

endpackage

// File: rtl/ras_ctrl_if.sv
// Push/pop connection between the RAS controller (master) and the call stack
// (slave). Signal names follow the controller's point of view.
interface ras_ctrl_if #(
  parameter int DW = 32
);
  logic          o_push_en;
  logic [DW-1:0] o_push_data;
  logic          o_pop_en;
  logic [DW-1:0] i_pop_data;
  logic          i_empty;
  logic          i_full;

  modport master (
    output o_push_en, o_push_data, o_pop_en,
    input  i_pop_data, i_empty, i_full
  );

  modport slave (
    input  o_push_en, o_push_data, o_pop_en,
    output i_pop_data, i_empty, i_full
  );
endinterface

// File: rtl/ras_pred_fifo.sv
// In-order queue of outstanding return predictions awaiting resolution.
// Read and write are both honoured in one cycle, including when full.
module ras_pred_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          wr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_i,
  input  logic          clr_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;
  logic          wr_ok;
  logic          rd_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_ok   = rd_i & ~empty_o;
  assign wr_ok   = wr_i & (~full_o | rd_ok);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + (AW+1)'(1);
      if (rd_ok) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (wr_ok && !clr_i) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: classifies JAL/JALR, drives the call stack,
// issues return predictions and scores them against resolved targets.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int DW     = 32,
  parameter int PQ_DPT = 4,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          i_vld,
  output logic          o_rdy,
  input  logic [31:0]   i_instr,
  input  logic [DW-1:0] i_pc,
  input  logic          i_flush,
  ras_ctrl_if.master    stk,
  output logic          o_pred_vld,
  output logic [DW-1:0] o_pred_target,
  input  logic          i_res_vld,
  input  logic [DW-1:0] i_res_target,
  output logic          o_mispred,
  output logic [DW-1:0] o_mispred_target,
  output logic [CW-1:0] o_hit_cnt,
  output logic [CW-1:0] o_miss_cnt
);

  ras_state_e    state_q;
  logic          pred_vld_q;
  logic [DW-1:0] pred_target_q;
  logic          mispred_q;
  logic [DW-1:0] mispred_target_q;
  logic [CW-1:0] hit_cnt_q;
  logic [CW-1:0] miss_cnt_q;

  logic          q_full;
  logic          q_empty;
  logic [DW-1:0] q_head;
  logic          acc;
  logic          push_en;
  logic          pop_en;
  logic          res_take;
  logic          res_hit;

  // Gating with aresetn drops the stack drive immediately when reset asserts.
  assign o_rdy    = aresetn & (state_q == RUN) & ~q_full;
  assign acc      = i_vld & o_rdy & ~i_flush;
  assign push_en  = acc & is_call(i_instr);
  assign pop_en   = acc & is_ret(i_instr) & ~stk.i_empty;
  assign res_take = (state_q == RUN) & i_res_vld & ~q_empty;
  assign res_hit  = (q_head == i_res_target);

  assign stk.o_push_en   = push_en;
  assign stk.o_push_data = aresetn ? (i_pc + DW'(4)) : '0;
  assign stk.o_pop_en    = pop_en;

  // The prediction enters the queue on the same edge that registers it, so
  // o_rdy sampled at accept time has already reserved the slot.
  ras_pred_fifo #(
    .DW    (DW),
    .DEPTH (PQ_DPT)
  ) u_pred_fifo (
    .clk       (clk),
    .aresetn   (aresetn),
    .wr_i      (pop_en),
    .wr_data_i (stk.i_pop_data),
    .rd_i      (res_take),
    .clr_i     (state_q == FLUSH),
    .full_o    (q_full),
    .empty_o   (q_empty),
    .head_o    (q_head)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q          <= RUN;
      pred_vld_q       <= 1'b0;
      pred_target_q    <= '0;
      mispred_q        <= 1'b0;
      mispred_target_q <= '0;
      hit_cnt_q        <= '0;
      miss_cnt_q       <= '0;
    end else begin
      pred_vld_q <= pop_en;
      if (pop_en) pred_target_q <= stk.i_pop_data;

      mispred_q <= res_take & ~res_hit;
      if (res_take && !res_hit) mispred_target_q <= i_res_target;

      // Counters stick at all-ones rather than wrapping.
      if (res_take && res_hit && !(&hit_cnt_q))   hit_cnt_q  <= hit_cnt_q + CW'(1);
      if (res_take && !res_hit && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + CW'(1);

      unique case (state_q)
        RUN:     if (i_flush) state_q <= FLUSH;
        FLUSH:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign o_pred_vld       = pred_vld_q;
  assign o_pred_target    = pred_target_q;
  assign o_mispred        = mispred_q;
  assign o_mispred_target = mispred_target_q;
  assign o_hit_cnt        = hit_cnt_q;
  assign o_miss_cnt       = miss_cnt_q;

endmodule
